// File: rtl/jam_pkg.sv
// Shared FSM type and constant helpers for the jam_search_param permutation-search engine.
package jam_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EVAL,
    CHECK,
    PERMUTE,
    DONE
  } jam_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int idxWidth(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic longint factorial(input int n);
    longint result;
    result = 1;
    for (int i = 2; i <= n; i++) result = result * longint'(i);
    return result;
  endfunction

  // Packed identity permutation: entry k holds k, at [k*w +: w].
  function automatic logic [63:0] identityPerm(input int n, input int w);
    logic [63:0] result;
    result = '0;
    for (int k = 0; k < n; k++) result = result | (64'(k) << (k * w));
    return result;
  endfunction

endpackage

// File: rtl/jam_search_param_if.sv
// Start/result handshake and cost-table address bus of the jam_search_param engine.
interface jam_search_param_if #(
  parameter int N      = 8,
  parameter int COST_W = 7,
  parameter int MC_W   = 16
);
  localparam int IDX_W = jam_pkg::idxWidth(N);
  localparam int ACC_W = COST_W + jam_pkg::clog2(N) + 1;

  logic                   start;
  logic [COST_W-1:0]      Cost;
  logic [IDX_W-1:0]       W;
  logic [IDX_W-1:0]       J;
  logic                   busy;
  logic                   Valid;
  logic [ACC_W-1:0]       MinCost;
  logic [MC_W-1:0]        MatchCount;
  logic [N*IDX_W-1:0]     BestPerm;

  modport master (
    output start, Cost,
    input  W, J, busy, Valid, MinCost, MatchCount, BestPerm
  );

  modport slave (
    input  start, Cost,
    output W, J, busy, Valid, MinCost, MatchCount, BestPerm
  );

endinterface

// File: rtl/jam_next_perm.sv
// Combinational lexicographic successor of a packed permutation, plus last-permutation flag.
module jam_next_perm #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N*IDX_W-1:0] seq,
  output logic [N*IDX_W-1:0] successor,
  output logic               is_last
);

  logic [IDX_W-1:0] a [N];
  logic [IDX_W-1:0] b [N];
  logic [IDX_W-1:0] c [N];
  logic [IDX_W-1:0] tmp;
  logic             found;
  int               pivot;
  int               swapIdx;

  // Entries are distinct, so the last larger element right of the pivot is the smallest one.
  always_comb begin
    successor = '0;
    found     = 1'b0;
    pivot     = 0;
    swapIdx   = 1;
    tmp       = '0;
    for (int k = 0; k < N; k++) begin
      a[k] = seq[k*IDX_W +: IDX_W];
      b[k] = a[k];
      c[k] = a[k];
    end
    for (int i = 0; i < N - 1; i++) begin
      if (a[i] < a[i+1]) begin
        pivot = i;
        found = 1'b1;
      end
    end
    swapIdx = pivot + 1;
    for (int k = 0; k < N; k++) begin
      if (k > pivot && a[k] > a[pivot]) swapIdx = k;
    end
    tmp          = b[pivot];
    b[pivot]     = b[swapIdx];
    b[swapIdx]   = tmp;
    for (int k = 0; k < N; k++) begin
      if (k > pivot) c[k] = b[N + pivot - k];
      else           c[k] = b[k];
    end
    for (int k = 0; k < N; k++) successor[k*IDX_W +: IDX_W] = c[k];
    is_last = !found;
  end

endmodule

// File: rtl/jam_search_param.sv
// Exhaustive N-worker/N-job assignment search: minimum total cost, its multiplicity and first best permutation.
// Optional branch-and-bound pruning is enabled by defining JAM_PRUNE_EN.
module jam_search_param
  import jam_pkg::*;
#(
  parameter int N      = 8,
  parameter int COST_W = 7,
  parameter int MC_W   = 16
) (
  input logic              CLK,
  input logic              RST_N,
  jam_search_param_if.slave bus
);

  localparam int IDX_W = idxWidth(N);
  localparam int ACC_W = COST_W + clog2(N) + 1;
  localparam int SEQ_W = N * IDX_W;
  localparam logic [SEQ_W-1:0] IDENT  = SEQ_W'(identityPerm(N, IDX_W));
  localparam logic [IDX_W-1:0] LAST_W = IDX_W'(N - 1);

  if (N < 2 || N > 8) begin : g_bad_n
    $error("jam_search_param: N must lie in 2..8");
  end
  if (factorial(N) >= (longint'(1) << MC_W)) begin : g_bad_mc
    $error("jam_search_param: MC_W too narrow to count N! permutations");
  end

  jam_state_t       state;
  jam_state_t       nextState;
  logic [SEQ_W-1:0] seq;
  logic [SEQ_W-1:0] successor;
  logic [SEQ_W-1:0] bestPerm;
  logic             isLast;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] accSum;
  logic [ACC_W-1:0] minCost;
  logic [MC_W-1:0]  matchCount;
  logic [IDX_W-1:0] wIdx;
  logic [IDX_W-1:0] jIdx;
  logic [IDX_W-1:0] wNext;
  logic             valid;
  logic             lastW;
  logic             pruned;
  logic             pruneHit;

  assign lastW  = (wIdx == LAST_W);
  assign wNext  = wIdx + IDX_W'(1);
  assign accSum = acc + ACC_W'(bus.Cost);

`ifdef JAM_PRUNE_EN
  // A partial sum already above the best total can only finish above it; equal totals must still be counted.
  assign pruneHit = (state == EVAL) && !lastW && (accSum > minCost);
`else
  assign pruneHit = 1'b0;
  assign pruned   = 1'b0;
`endif

  jam_next_perm #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_next_perm (
    .seq       (seq),
    .successor (successor),
    .is_last   (isLast)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE, DONE: if (bus.start) nextState = EVAL;
      EVAL:       if (lastW || pruneHit) nextState = CHECK;
      CHECK:      nextState = isLast ? DONE : PERMUTE;
      PERMUTE:    nextState = EVAL;
      default:    nextState = IDLE;
    endcase
  end

  // Datapath: accumulation and addressing in EVAL, result update in CHECK, stepping in PERMUTE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      seq        <= IDENT;
      acc        <= '0;
      wIdx       <= '0;
      jIdx       <= '0;
      valid      <= 1'b0;
      minCost    <= '1;
      matchCount <= '0;
      bestPerm   <= IDENT;
`ifdef JAM_PRUNE_EN
      pruned     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            seq        <= IDENT;
            bestPerm   <= IDENT;
            minCost    <= '1;
            matchCount <= '0;
            acc        <= '0;
            wIdx       <= '0;
            jIdx       <= '0;
            valid      <= 1'b0;
`ifdef JAM_PRUNE_EN
            pruned     <= 1'b0;
`endif
          end
        end
        EVAL: begin
          acc <= accSum;
          if (lastW || pruneHit) begin
            wIdx <= '0;
            jIdx <= seq[IDX_W-1:0];
          end else begin
            wIdx <= wNext;
            jIdx <= seq[int'(wNext)*IDX_W +: IDX_W];
          end
`ifdef JAM_PRUNE_EN
          pruned <= pruneHit;
`endif
        end
        CHECK: begin
          if (!pruned) begin
            if (acc < minCost) begin
              minCost    <= acc;
              matchCount <= MC_W'(1);
              bestPerm   <= seq;
            end else if (acc == minCost) begin
              matchCount <= matchCount + MC_W'(1);
            end
          end
          if (isLast) valid <= 1'b1;
        end
        PERMUTE: begin
          seq  <= successor;
          acc  <= '0;
          wIdx <= '0;
          jIdx <= successor[IDX_W-1:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.W          = wIdx;
  assign bus.J          = jIdx;
  assign bus.busy       = (state == EVAL) || (state == CHECK) || (state == PERMUTE);
  assign bus.Valid      = valid;
  assign bus.MinCost    = minCost;
  assign bus.MatchCount = matchCount;
  assign bus.BestPerm   = bestPerm;

endmodule

// File: doc/jam_search_param.md
Name: jam_search_param

Overview:
- Parametrised successor to the fixed 8x8 job-assignment engine.
- Runs an exhaustive lexicographic permutation search over N workers and N jobs. For each permutation it sums externally supplied costs, then reports the minimum total, the number of permutations that achieve it, and the first permutation that achieves it.
- Adds a start/busy handshake and restartability.
- Sits beside the cost ROM/table and drives its W/J address.

Parameters:
- N, 8, workers = jobs; legal range 2..8.
- COST_W, 7, width of one Cost entry.
- MC_W, 16, MatchCount width; must satisfy N! < 2^MC_W.
- Derived localparams (not overridable):
  - IDX_W = max(1, clog2(N)).
  - ACC_W = COST_W + clog2(N) + 1.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE or DONE.
- Cost  in  COST_W  combinational cost of (W,J); sampled at the rising edge ending each EVAL cycle.
- W  out  IDX_W  worker index (registered).
- J  out  IDX_W  job index = seq[W] (registered).
- busy  out  1  high in EVAL/CHECK/PERMUTE.
- Valid  out  1  results valid; held until the next accepted start.
- MinCost  out  ACC_W  minimum total cost.
- MatchCount  out  MC_W  number of permutations whose total equals MinCost.
- BestPerm  out  N*IDX_W  job for worker k at [k*IDX_W +: IDX_W].

Behaviour:
- Reset (async, RST_N=0) values:
  - state IDLE.
  - W=0, J=0, busy=0, Valid=0.
  - MinCost = all ones, MatchCount = 0, BestPerm = identity.
  - seq = identity, acc = 0.
- FSM states: IDLE, EVAL, CHECK, PERMUTE, DONE.
- IDLE/DONE, start=1:
  - seq and BestPerm go to identity; MinCost to all ones; MatchCount to 0; acc to 0; W to 0; Valid to 0.
  - Next state EVAL.
- start while busy is ignored.
- EVAL:
  - Each cycle: acc <= acc + Cost; W <= W+1; J <= seq[W+1].
  - After N cycles (Cost sampled at W = N-1), go to CHECK.
- CHECK (one cycle) compares the completed total T = acc:
  - T < MinCost: MinCost <= T, MatchCount <= 1, BestPerm <= seq.
  - T == MinCost: MatchCount <= MatchCount+1; BestPerm unchanged (keeps the lexicographically first match).
  - Then: if seq is strictly descending, go to DONE and set Valid <= 1; otherwise go to PERMUTE.
- PERMUTE (one cycle):
  - seq <= lexicographic successor (pivot i = largest index with seq[i] < seq[i+1]; swap with smallest larger element right of i; reverse suffix i+1..N-1).
  - acc <= 0, W <= 0, J <= successor[0].
  - Next state EVAL.
- Arithmetic: unsigned; acc cannot overflow at ACC_W, since N*(2^COST_W - 1) fits.
- Latency (no prune): Valid rises on the rising edge N!*(N+2)-1 edges after the start-sampling edge.
  - N=3: 29. N=8: 403199.
- Reset mid-operation aborts immediately to reset values; no partial result is visible.
- Outputs MinCost, MatchCount and BestPerm are only meaningful while Valid=1.

Optional Feature:
- Macro: JAM_PRUNE_EN (branch-and-bound pruning).
- Defined:
  - In EVAL, if acc + Cost > MinCost (strict) with W < N-1, the permutation is abandoned.
  - Next state is CHECK with an internal pruned flag; CHECK then makes no MinCost/MatchCount/BestPerm update and only performs the last-permutation test.
  - Results are identical to the unpruned build; cycle count is ≤ the unpruned count.
- Undefined: no pruning; exact latency formula above holds.

Decomposition:
- Package jam_pkg:
  - FSM state enum.
  - clog2 function.
  - Factorial constant function, used for MC_W assertion.
- Sub-module jam_next_perm (combinational):
  - Inputs seq; outputs successor and is_last.
  - Parametrised on N and IDX_W.
  - Instantiated once; used by CHECK (is_last) and PERMUTE (successor).

Test Plan:
- Basic search: N=3, Cost = (W==J) ? 0 : 1 -> MinCost=0, MatchCount=1, BestPerm={2,1,0} (worker2..0), Valid 29 edges after start.
- Uniform costs: N=4, Cost = 7 everywhere -> MinCost=28, MatchCount=24, BestPerm=identity; a stuck permutation is visible as a wrong count.
- Full size: N=8, Cost=127 everywhere -> MinCost=1016, MatchCount=40320, no overflow.
- Random matrix: N=5, random 7-bit table -> all outputs match a software reference model. Repeat the run with JAM_PRUNE_EN: identical results and fewer cycles.
- Handshake: start pulsed while busy is ignored. RST_N low at cycle 50 -> all outputs at reset values. A new start after Valid clears Valid the next cycle and reruns with identical results.
- Address protocol: during EVAL, W steps 0..N-1 and J equals the current permutation entry; checked against the model every cycle.
